// File: rtl/axi_mem_subordinate.sv
// AXI4 subordinate backed by an internal flop-array memory: independent read and write engines, FIXED/INCR/WRAP bursts.
// Optional macro AXI_MEM_SUB_BYPASS_EN forwards same-cycle write bytes into a colliding read beat.
module axi_mem_subordinate #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ID_WIDTH-1:0]     awid_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic [7:0]              awlen_i,
    input  logic [2:0]              awsize_i,
    input  logic [1:0]              awburst_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wlast_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ID_WIDTH-1:0]     bid_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ID_WIDTH-1:0]     arid_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic [7:0]              arlen_i,
    input  logic [2:0]              arsize_i,
    input  logic [1:0]              arburst_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [ID_WIDTH-1:0]     rid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rlast_o,
    output logic                    rvalid_o,
    input  logic                    rready_i
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LG = $clog2(NB);
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0] len,
                                                        input logic [2:0] size,
                                                        input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        incr = addr + (ONE << size);
        mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
        case (burst)
            BURST_INCR: next_addr = incr;
            BURST_WRAP: next_addr = (addr & ~mask) | (incr & mask);
            default:    next_addr = addr;
        endcase
    endfunction

    function automatic logic hdr_err(input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        hdr_err = (size > 3'(LG)) || (burst == 2'b11) ||
                  ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - BASE_ADDR;
        in_range = (addr >= BASE_ADDR) && ((off >> LG) < ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = (addr - BASE_ADDR) >> LG;
        word_idx = IW'(off);
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write engine ----------------
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    w_state_t              w_state_reg;
    logic [ID_WIDTH-1:0]   w_id_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg;
    logic [7:0]            w_len_reg;
    logic [7:0]            w_cnt_reg;
    logic [2:0]            w_size_reg;
    logic [1:0]            w_burst_reg;
    logic                  w_err_reg;
    logic                  w_last_beat;
    logic                  w_hit;
    logic                  mem_we;
    logic [IW-1:0]         w_idx;

    assign awready_o   = (w_state_reg == W_IDLE) && !rst_i;
    assign wready_o    = (w_state_reg == W_DATA) && !rst_i;
    assign bvalid_o    = (w_state_reg == W_RESP) && !rst_i;
    assign bid_o       = bvalid_o ? w_id_reg : '0;
    assign bresp_o     = (bvalid_o && w_err_reg) ? RESP_SLVERR : RESP_OKAY;
    assign w_last_beat = (w_cnt_reg == w_len_reg);
    assign w_hit       = in_range(w_addr_reg);
    assign w_idx       = word_idx(w_addr_reg);
    assign mem_we      = wvalid_i && wready_o && !w_err_reg && w_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_len_reg   <= '0;
            w_cnt_reg   <= '0;
            w_size_reg  <= '0;
            w_burst_reg <= BURST_FIXED;
            w_err_reg   <= 1'b0;
        end else begin
            case (w_state_reg)
                W_IDLE: if (awvalid_i) begin
                    w_id_reg    <= awid_i;
                    w_addr_reg  <= awaddr_i;
                    w_len_reg   <= awlen_i;
                    w_size_reg  <= awsize_i;
                    w_burst_reg <= awburst_i;
                    w_cnt_reg   <= '0;
                    w_err_reg   <= hdr_err(awlen_i, awsize_i, awburst_i);
                    w_state_reg <= W_DATA;
                end
                W_DATA: if (wvalid_i) begin
                    // Beat count alone terminates the burst; a misplaced wlast only flags the error.
                    if (!w_hit || (wlast_i != w_last_beat))
                        w_err_reg <= 1'b1;
                    if (w_last_beat) begin
                        w_state_reg <= W_RESP;
                    end else begin
                        w_cnt_reg  <= w_cnt_reg + 8'd1;
                        w_addr_reg <= next_addr(w_addr_reg, w_len_reg, w_size_reg, w_burst_reg);
                    end
                end
                W_RESP: if (bready_i) w_state_reg <= W_IDLE;
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b])
                    mem[w_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    r_state_t              r_state_reg;
    logic [ID_WIDTH-1:0]   r_id_reg;
    logic [ADDR_WIDTH-1:0] r_addr_reg;
    logic [7:0]            r_len_reg;
    logic [7:0]            r_cnt_reg;
    logic [2:0]            r_size_reg;
    logic [1:0]            r_burst_reg;
    logic                  r_err_reg;
    logic                  r_ok;
    logic [IW-1:0]         r_idx;
    logic [DATA_WIDTH-1:0] mem_rd;
    logic [DATA_WIDTH-1:0] r_word;

    assign arready_o = (r_state_reg == R_IDLE) && !rst_i;
    assign rvalid_o  = (r_state_reg == R_DATA) && !rst_i;
    assign rid_o     = rvalid_o ? r_id_reg : '0;
    assign rlast_o   = rvalid_o && (r_cnt_reg == r_len_reg);
    assign r_ok      = !r_err_reg && in_range(r_addr_reg);
    assign rresp_o   = (rvalid_o && !r_ok) ? RESP_SLVERR : RESP_OKAY;
    assign rdata_o   = (rvalid_o && r_ok) ? r_word : '0;
    assign r_idx     = word_idx(r_addr_reg);
    assign mem_rd    = mem[r_idx];

`ifdef AXI_MEM_SUB_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = mem_we && (w_idx == r_idx);
    for (genvar gi = 0; gi < NB; gi++) begin : g_bypass
        assign r_word[gi*8 +: 8] = (bypass_hit && wstrb_i[gi]) ? wdata_i[gi*8 +: 8] : mem_rd[gi*8 +: 8];
    end
`else
    // Write commits at the clock edge, so a colliding read sees the old word.
    assign r_word = mem_rd;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_size_reg  <= '0;
            r_burst_reg <= BURST_FIXED;
            r_err_reg   <= 1'b0;
        end else begin
            case (r_state_reg)
                R_IDLE: if (arvalid_i) begin
                    r_id_reg    <= arid_i;
                    r_addr_reg  <= araddr_i;
                    r_len_reg   <= arlen_i;
                    r_size_reg  <= arsize_i;
                    r_burst_reg <= arburst_i;
                    r_cnt_reg   <= '0;
                    r_err_reg   <= hdr_err(arlen_i, arsize_i, arburst_i);
                    r_state_reg <= R_DATA;
                end
                R_DATA: if (rready_i) begin
                    if (r_cnt_reg == r_len_reg) begin
                        r_state_reg <= R_IDLE;
                    end else begin
                        r_cnt_reg  <= r_cnt_reg + 8'd1;
                        r_addr_reg <= next_addr(r_addr_reg, r_len_reg, r_size_reg, r_burst_reg);
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_mem_subordinate.sv
// Directed self-checking bench for axi_mem_subordinate: bursts, narrow writes, errors, backpressure, reset.
module tb_axi_mem_subordinate;
    localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;
    localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic [3:0]  awid = '0, arid = '0;
    logic [31:0] awaddr = '0, araddr = '0;
    logic [7:0]  awlen = '0, arlen = '0;
    logic [2:0]  awsize = '0, arsize = '0;
    logic [1:0]  awburst = '0, arburst = '0;
    logic        awvalid = 1'b0, arvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0;
    logic [63:0] wdata = '0;
    logic [7:0]  wstrb = '0;
    logic        bready = 1'b0, rready = 1'b0;
    logic        awready, arready, wready, bvalid, rvalid, rlast;
    logic [3:0]  bid, rid;
    logic [1:0]  bresp, rresp;
    logic [63:0] rdata;

    int checks = 0;
    int errors = 0;

    logic [63:0] wbuf [16];
    logic [63:0] rbuf [16];
    logic [1:0]  rresp_buf [16];
    logic        rlast_buf [16];
    logic [3:0]  rid_last;
    int          rbeats;

    axi_mem_subordinate dut (
        .clk_i(clk), .rst_i(rst),
        .awid_i(awid), .awaddr_i(awaddr), .awlen_i(awlen), .awsize_i(awsize), .awburst_i(awburst),
        .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast), .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .arid_i(arid), .araddr_i(araddr), .arlen_i(arlen), .arsize_i(arsize), .arburst_i(arburst),
        .arvalid_i(arvalid), .arready_o(arready),
        .rid_o(rid), .rdata_o(rdata), .rresp_o(rresp), .rlast_o(rlast), .rvalid_o(rvalid), .rready_i(rready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        #1;
        while (!awready && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL aw_timeout: awready=%0b required 1", awready); end
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [7:0] len, input logic [7:0] strb, input int last_at);
        for (int b = 0; b <= int'(len); b++) begin
            int n = 0;
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = strb; wlast = (b == last_at);
            #1;
            while (!wready && n < 100) begin @(negedge clk); #1; n++; end
            if (n >= 100) begin checks++; errors++; $display("FAIL w_timeout: beat %0d wready=%0b required 1", b, wready); end
            @(negedge clk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_recv(output logic [3:0] id_o, output logic [1:0] resp_o);
        int n = 0;
        bready = 1'b1;
        #1;
        while (!bvalid && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%0b required 1", bvalid); end
        id_o = bid; resp_o = bresp;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                             input int last_at, output logic [3:0] bid_o, output logic [1:0] bresp_o);
        aw_send(id, addr, len, size, burst);
        w_send(len, strb, last_at);
        b_recv(bid_o, bresp_o);
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output logic first);
        int n = 0;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        #1;
        while (!arready && n < 100) begin @(negedge clk); #1; n++; end
        if (n >= 100) begin checks++; errors++; $display("FAIL ar_timeout: arready=%0b required 1", arready); end
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        first = rvalid;
    endtask

    task automatic r_recv(input logic [7:0] len);
        int n = 0;
        int beat = 0;
        rready = 1'b1;
        while (beat <= int'(len) && n < 100) begin
            if (rvalid) begin
                rbuf[beat] = rdata; rresp_buf[beat] = rresp; rlast_buf[beat] = rlast; rid_last = rid;
                beat++;
            end
            @(negedge clk); #1; n++;
        end
        rready = 1'b0;
        rbeats = beat;
        if (n >= 100) begin checks++; errors++; $display("FAIL r_timeout: beats=%0d required %0d", beat, int'(len) + 1); end
    endtask

    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output logic first);
        ar_send(id, addr, len, size, burst, first);
        r_recv(len);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %0b want 0", awready); end
        checks++; if (arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %0b want 0", arready); end
        checks++; if (wready  !== 1'b0) begin errors++; $display("FAIL rst_wready: got %0b want 0", wready); end
        checks++; if (bvalid  !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %0b want 0", bvalid); end
        checks++; if (rvalid  !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %0b want 0", rvalid); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (awready !== 1'b1) begin errors++; $display("FAIL post_rst_awready: got %0b want 1", awready); end
        checks++; if (arready !== 1'b1) begin errors++; $display("FAIL post_rst_arready: got %0b want 1", arready); end
        $display("test_reset done");
    endtask

    task automatic test_incr();
        logic [3:0] b_id; logic [1:0] b_resp; logic first;
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
        axi_write(4'h1, 32'h40, 8'd3, 3'd3, INCR, 8'hFF, 3, b_id, b_resp);
        checks++; if (b_resp !== OKAY) begin errors++; $display("FAIL incr_bresp: got %0d want 0", b_resp); end
        checks++; if (b_id !== 4'h1) begin errors++; $display("FAIL incr_bid: got %0h want 1", b_id); end
        axi_read(4'h2, 32'h40, 8'd3, 3'd3, INCR, first);
        checks++; if (first !== 1'b1) begin errors++; $display("FAIL incr_rvalid_latency: got %0b want 1", first); end
        checks++; if (rbeats !== 4) begin errors++; $display("FAIL incr_rbeats: got %0d want 4", rbeats); end
        checks++; if (rid_last !== 4'h2) begin errors++; $display("FAIL incr_rid: got %0h want 2", rid_last); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbuf[i] !== exp_d[i]) begin errors++; $display("FAIL incr_rdata[%0d]: got %h want %h", i, rbuf[i], exp_d[i]); end
            checks++; if (rlast_buf[i] !== (i == 3)) begin errors++; $display("FAIL incr_rlast[%0d]: got %0b want %0b", i, rlast_buf[i], i == 3); end
            checks++; if (rresp_buf[i] !== OKAY) begin errors++; $display("FAIL incr_rresp[%0d]: got %0d want 0", i, rresp_buf[i]); end
        end
        $display("test_incr done");
    endtask

    task automatic test_wrap();
        logic first;
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h4444_4444_4444_4444; exp_d[1] = 64'h1111_1111_1111_1111;
        exp_d[2] = 64'h2222_2222_2222_2222; exp_d[3] = 64'h3333_3333_3333_3333;
        axi_read(4'h3, 32'h58, 8'd3, 3'd3, WRAP, first);
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbuf[i] !== exp_d[i]) begin errors++; $display("FAIL wrap_rdata[%0d]: got %h want %h", i, rbuf[i], exp_d[i]); end
        end
        checks++; if (rresp_buf[0] !== OKAY) begin errors++; $display("FAIL wrap_rresp: got %0d want 0", rresp_buf[0]); end
        $display("test_wrap done");
    endtask

    task automatic test_fixed_partial();
        logic [3:0] b_id; logic [1:0] b_resp; logic first;
        wbuf[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        axi_write(4'h4, 32'h10, 8'd0, 3'd3, INCR, 8'hFF, 0, b_id, b_resp);
        checks++; if (b_resp !== OKAY) begin errors++; $display("FAIL fixed_bresp: got %0d want 0", b_resp); end
        axi_read(4'h5, 32'h10, 8'd2, 3'd3, FIXED, first);
        checks++; if (rbeats !== 3) begin errors++; $display("FAIL fixed_rbeats: got %0d want 3", rbeats); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rbuf[i] !== 64'hAAAA_AAAA_AAAA_AAAA) begin errors++; $display("FAIL fixed_rdata[%0d]: got %h want aaaaaaaaaaaaaaaa", i, rbuf[i]); end
            checks++; if (rlast_buf[i] !== (i == 2)) begin errors++; $display("FAIL fixed_rlast[%0d]: got %0b want %0b", i, rlast_buf[i], i == 2); end
        end
        wbuf[0] = 64'h5555_5555_5555_5555;
        axi_write(4'h4, 32'h10, 8'd0, 3'd3, INCR, 8'h0F, 0, b_id, b_resp);
        axi_read(4'h5, 32'h10, 8'd0, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== 64'hAAAA_AAAA_5555_5555) begin errors++; $display("FAIL partial_rdata: got %h want aaaaaaaa55555555", rbuf[0]); end
        $display("test_fixed_partial done");
    endtask

    task automatic test_errors();
        logic [3:0] b_id; logic [1:0] b_resp; logic first;
        wbuf[0] = 64'hDEAD_DEAD_DEAD_DEAD; wbuf[1] = 64'hBEEF_BEEF_BEEF_BEEF;
        axi_write(4'h6, 32'h40, 8'd1, 3'd4, INCR, 8'hFF, 1, b_id, b_resp);
        checks++; if (b_resp !== SLVERR) begin errors++; $display("FAIL badsize_bresp: got %0d want 2", b_resp); end
        axi_read(4'h2, 32'h40, 8'd1, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL badsize_mem0: got %h want 1111111111111111", rbuf[0]); end
        checks++; if (rbuf[1] !== 64'h2222_2222_2222_2222) begin errors++; $display("FAIL badsize_mem1: got %h want 2222222222222222", rbuf[1]); end
        axi_read(4'h7, 32'h2000, 8'd0, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== 64'h0) begin errors++; $display("FAIL oor_rdata: got %h want 0", rbuf[0]); end
        checks++; if (rresp_buf[0] !== SLVERR) begin errors++; $display("FAIL oor_rresp: got %0d want 2", rresp_buf[0]); end
        for (int i = 0; i < 4; i++) wbuf[i] = 64'h0F0F_0000_0000_0000 | 64'(i);
        axi_write(4'h8, 32'h80, 8'd3, 3'd3, INCR, 8'hFF, 1, b_id, b_resp);
        checks++; if (b_resp !== SLVERR) begin errors++; $display("FAIL early_wlast_bresp: got %0d want 2", b_resp); end
        checks++; if (b_id !== 4'h8) begin errors++; $display("FAIL early_wlast_bid: got %0h want 8", b_id); end
        axi_read(4'h9, 32'h40, 8'd2, 3'd3, WRAP, first);
        checks++; if (rbeats !== 3) begin errors++; $display("FAIL badwrap_rbeats: got %0d want 3", rbeats); end
        checks++; if (rresp_buf[0] !== SLVERR || rbuf[0] !== 64'h0) begin errors++; $display("FAIL badwrap_beat0: resp %0d data %h want 2/0", rresp_buf[0], rbuf[0]); end
        $display("test_errors done");
    endtask

    task automatic test_backpressure();
        logic first; logic [3:0] b_id; logic [1:0] b_resp;
        logic [63:0] hold_d; logic hold_l; logic [3:0] hold_id; logic have_hold;
        int got = 0;
        logic [63:0] exp_d [4];
        exp_d[0] = 64'h1111_1111_1111_1111; exp_d[1] = 64'h2222_2222_2222_2222;
        exp_d[2] = 64'h3333_3333_3333_3333; exp_d[3] = 64'h4444_4444_4444_4444;
        have_hold = 1'b0; hold_d = '0; hold_l = 1'b0; hold_id = '0;
        ar_send(4'hA, 32'h40, 8'd3, 3'd3, INCR, first);
        for (int k = 0; k < 20 && got < 4; k++) begin
            rready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            if (have_hold) begin
                checks++;
                if (rvalid !== 1'b1 || rdata !== hold_d || rlast !== hold_l || rid !== hold_id) begin
                    errors++; $display("FAIL r_hold_stable: got v%0b %h l%0b id%0h want v1 %h l%0b id%0h", rvalid, rdata, rlast, rid, hold_d, hold_l, hold_id);
                end
                have_hold = 1'b0;
            end
            if (rvalid) begin
                if (rready) begin rbuf[got] = rdata; got++; end
                else begin hold_d = rdata; hold_l = rlast; hold_id = rid; have_hold = 1'b1; end
            end
            @(negedge clk); #1;
        end
        rready = 1'b0;
        checks++; if (got !== 4) begin errors++; $display("FAIL bp_rbeats: got %0d want 4", got); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rbuf[i] !== exp_d[i]) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want %h", i, rbuf[i], exp_d[i]); end
        end
        wbuf[0] = 64'hB0B0_B0B0_B0B0_B0B0;
        aw_send(4'hC, 32'h100, 8'd0, 3'd3, INCR);
        w_send(8'd0, 8'hFF, 0);
        bready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checks++;
            if (bvalid !== 1'b1 || bid !== 4'hC || bresp !== OKAY) begin
                errors++; $display("FAIL b_hold[%0d]: got v%0b id%0h r%0d want v1 idc r0", k, bvalid, bid, bresp);
            end
        end
        b_recv(b_id, b_resp);
        #1;
        checks++; if (bvalid !== 1'b0) begin errors++; $display("FAIL b_drop: got %0b want 0", bvalid); end
        $display("test_backpressure done");
    endtask

    task automatic test_concurrent();
        logic [3:0] b_id; logic [1:0] b_resp; logic first;
        wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hFEDC_BA98_7654_3210;
        fork
            axi_write(4'h5, 32'h100, 8'd1, 3'd3, INCR, 8'hFF, 1, b_id, b_resp);
            axi_read(4'h9, 32'h40, 8'd3, 3'd3, INCR, first);
        join
        checks++; if (b_id !== 4'h5 || b_resp !== OKAY) begin errors++; $display("FAIL conc_b: got id%0h r%0d want id5 r0", b_id, b_resp); end
        checks++; if (rid_last !== 4'h9) begin errors++; $display("FAIL conc_rid: got %0h want 9", rid_last); end
        checks++; if (rbuf[3] !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL conc_rdata3: got %h want 4444444444444444", rbuf[3]); end
        axi_read(4'h1, 32'h100, 8'd1, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== 64'h0123_4567_89AB_CDEF) begin errors++; $display("FAIL conc_mem0: got %h want 0123456789abcdef", rbuf[0]); end
        checks++; if (rbuf[1] !== 64'hFEDC_BA98_7654_3210) begin errors++; $display("FAIL conc_mem1: got %h want fedcba9876543210", rbuf[1]); end
        $display("test_concurrent done");
    endtask

    task automatic test_midburst_reset();
        logic [3:0] b_id; logic [1:0] b_resp; logic first; logic saw_b;
        for (int i = 0; i < 8; i++) wbuf[i] = 64'hC0C0_0000_0000_0000 | 64'(i + 1);
        aw_send(4'h3, 32'h200, 8'd7, 3'd3, INCR);
        for (int b = 0; b < 2; b++) begin
            wvalid = 1'b1; wdata = wbuf[b]; wstrb = 8'hFF; wlast = 1'b0;
            @(negedge clk);
        end
        wdata = wbuf[2]; rst = 1'b1;
        #1;
        checks++; if (wready !== 1'b0 || awready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got w%0b aw%0b want 0 0", wready, awready); end
        @(negedge clk);
        rst = 1'b0; wvalid = 1'b0;
        #1;
        checks++; if (awready !== 1'b1 || arready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle: got aw%0b ar%0b want 1 1", awready, arready); end
        saw_b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bvalid) saw_b = 1'b1;
            @(negedge clk); #1;
        end
        checks++; if (saw_b !== 1'b0) begin errors++; $display("FAIL mid_rst_bvalid: got 1 want 0"); end
        axi_read(4'h4, 32'h200, 8'd1, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== wbuf[0]) begin errors++; $display("FAIL mid_rst_beat0: got %h want %h", rbuf[0], wbuf[0]); end
        checks++; if (rbuf[1] !== wbuf[1]) begin errors++; $display("FAIL mid_rst_beat1: got %h want %h", rbuf[1], wbuf[1]); end
        wbuf[0] = 64'h7777_7777_7777_7777;
        axi_write(4'hE, 32'h200, 8'd0, 3'd3, INCR, 8'hFF, 0, b_id, b_resp);
        checks++; if (b_id !== 4'hE || b_resp !== OKAY) begin errors++; $display("FAIL post_rst_b: got id%0h r%0d want ide r0", b_id, b_resp); end
        axi_read(4'h4, 32'h200, 8'd0, 3'd3, INCR, first);
        checks++; if (rbuf[0] !== 64'h7777_7777_7777_7777) begin errors++; $display("FAIL post_rst_rdata: got %h want 7777777777777777", rbuf[0]); end
        $display("test_midburst_reset done");
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_partial();
        test_errors();
        test_backpressure();
        test_concurrent();
        test_midburst_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi_mem_subordinate.md
Name: axi_mem_subordinate

Overview:
- AXI4 subordinate endpoint with an internal flop-array memory.
- Sits on a subordinate port of the system AXI crossbar and terminates manager traffic (I$, D$, DMA, PTW).
- Serves as on-chip scratch RAM and as the reference responder for interconnect verification.
- Independent read and write engines; supports FIXED, INCR and WRAP bursts, one outstanding transaction per direction.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, data width (power of 2, >= 32); NB = DATA_WIDTH/8 bytes per beat.
- ID_WIDTH, 4, AXI ID width.
- MEM_DEPTH, 1024, memory words of DATA_WIDTH bits.
- BASE_ADDR, 32'h0, byte address of word 0; must be NB-aligned.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- awid_i/awaddr_i/awlen_i/awsize_i/awburst_i  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
- awvalid_i in 1; awready_o out 1.
- wdata_i/wstrb_i/wlast_i  in  DATA_WIDTH/NB/1  write data.
- wvalid_i in 1; wready_o out 1.
- bid_o/bresp_o  out  ID_WIDTH/2  write response.
- bvalid_o out 1; bready_i in 1.
- arid_i/araddr_i/arlen_i/arsize_i/arburst_i  in  ID_WIDTH/ADDR_WIDTH/8/3/2  read address.
- arvalid_i in 1; arready_o out 1.
- rid_o/rdata_o/rresp_o/rlast_o  out  ID_WIDTH/DATA_WIDTH/2/1  read data.
- rvalid_o out 1; rready_i in 1.

Behaviour:
- Reset: one clock, clk_i; reset is synchronous and active-high (rst_i). While rst_i=1 all outputs are 0 and both FSMs go to IDLE. Memory contents are not reset.
- Mid-burst reset: the burst is abandoned and no B or R response is issued. Beats already written persist.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - awready_o = (state==W_IDLE) && !rst_i.
  - AW handshake captures id, addr, len, size, burst; beat counter cleared; err flag = (awsize_i > log2(NB)) || (awburst_i==2'b11) || (WRAP && awlen_i not in {1,3,7,15}).
  - W_DATA: wready_o=1. Each W handshake writes the bytes enabled by wstrb_i to word (addr-BASE_ADDR)>>log2(NB), only if !err and the address is in range.
  - An out-of-range beat sets err.
  - wlast_i mismatch (asserted before beat len, or absent at beat len) sets err.
  - The burst always ends after exactly len+1 beats.
  - W_RESP: bvalid_o=1, bid_o=captured id, bresp_o = err ? SLVERR(2'b10) : OKAY(2'b00). Held until bready_i, then W_IDLE.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - arready_o = (state==R_IDLE) && !rst_i.
  - AR handshake at cycle N gives rvalid_o=1 at N+1. Error rules are the same as for write.
  - rdata_o = mem[word(addr_q)], combinational from the array. It is 0 with rresp_o=SLVERR when err is set or the beat is out of range; otherwise rresp_o=OKAY.
  - rlast_o=1 on beat len. Each R handshake advances the address and beat count, giving back-to-back beats at one per cycle while rready_i=1.
  - On the last handshake the FSM returns to R_IDLE. arready_o rises the following cycle, so there is a minimum 1 idle cycle between bursts.
  - rvalid_o and all R fields are held stable while rready_i=0.
- Address update, per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size), modulo 2^ADDR_WIDTH.
  - WRAP: container = (len+1)<<size, aligned base = addr & ~(container-1); next = base | ((addr + (1<<size)) & (container-1)).
  - No 4 KB boundary checking.
- Narrow transfers: write lanes come from wstrb_i as given. Reads return the full word.
- Read-during-write: the same word, same cycle read returns the old contents, because the write commits at the clock edge.
- AW/W and AR/R are fully independent and may be active in the same cycle.

Optional Feature:
- AXI_MEM_SUB_BYPASS_EN:
  - When defined, an R beat whose word matches a W beat being written in the same cycle returns merged data. Strobed bytes come from wdata_i; the remaining bytes come from the array.
  - When undefined, the R beat returns the old data.

Test Plan:
- INCR write, awaddr=0x40, awlen=3, awsize=3, data 0x11..,0x22..,0x33..,0x44.. with wstrb=0xFF -> bresp=OKAY. INCR read of the same range returns the 4 words in order, rlast only on beat 3, rvalid first seen one cycle after the AR handshake.
- WRAP read, araddr=0x58, len=3, size=3 -> word addresses 0x58, 0x40, 0x48, 0x50.
- FIXED read at 0x10, len=2 -> 3 identical words. Partial write with wstrb=0x0F -> only the low 4 bytes change.
- Error cases:
  - awsize=4 with DATA_WIDTH=64 -> all beats accepted, memory unchanged, bresp=SLVERR.
  - Read at BASE_ADDR + MEM_DEPTH*NB -> rdata=0, rresp=SLVERR.
  - wlast asserted on beat 1 of a len=3 burst -> 4 beats consumed, bresp=SLVERR.
- Backpressure: rready toggles 1,0,0,1 and bready held low for 5 cycles -> R fields and bvalid/bid/bresp stay stable, no beat is lost or duplicated. Concurrent write and read with different IDs complete with the correct bid/rid.
- Reset asserted on beat 2 of a len=7 write -> no bvalid. After reset, awready=1 and arready=1, beats 0–1 persist in memory, and a new burst completes normally.
